// File: rtl/fetch_stage.sv
// Front of the rvga pipeline: owns the PC, issues in-order imem requests,
// buffers returned instructions for decode and squashes stale fetches on redirect.
module fetch_stage #(
  parameter logic [31:0] reset_pc_p        = 32'h0000_0000,
  parameter int unsigned max_outstanding_p = 2,
  parameter int unsigned buf_depth_p       = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_v_i,
  input  logic        btaken_i,
  input  logic [31:0] br_tgt_i,
  output logic        imem_req_v_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_req_ready_i,
  input  logic        imem_resp_v_i,
  input  logic [31:0] imem_resp_data_i,
  output logic        instr_v_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  localparam int unsigned OUT_W = $clog2(max_outstanding_p + 1);
  localparam int unsigned CNT_W = $clog2(buf_depth_p + 1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t           state;
  logic [31:0]      pc;
  logic [OUT_W-1:0] outstanding;
  logic [OUT_W-1:0] discard_cnt;
  logic [OUT_W-1:0] tag_cnt;
  logic [CNT_W-1:0] count;

  logic [31:0] tag_q    [max_outstanding_p];
  logic [31:0] buf_pc   [buf_depth_p];
  logic [31:0] buf_data [buf_depth_p];

  logic             accept;
  logic             drop;
  logic             push;
  logic             pop;
  logic [OUT_W-1:0] stale_left;
  logic [CNT_W-1:0] buf_wr_idx;
  logic [OUT_W-1:0] tag_wr_idx;

  always_comb begin
    imem_req_v_o = !rst_i && !btaken_i
                   && (32'(outstanding) < max_outstanding_p)
                   && (32'(outstanding) + 32'(count) < buf_depth_p);
    accept       = imem_req_v_o && imem_req_ready_i;
    // A response in the redirect cycle is already stale, even though FLUSH starts next cycle.
    drop         = imem_resp_v_i && (btaken_i || state == FLUSH);
    push         = imem_resp_v_i && !drop;
    instr_v_o    = !rst_i && !btaken_i && (count != '0);
    pop          = instr_v_o && !stall_v_i;
    stale_left   = outstanding - OUT_W'(imem_resp_v_i);
    buf_wr_idx   = count - CNT_W'(pop);
    tag_wr_idx   = tag_cnt - OUT_W'(push);
  end

  assign imem_addr_o = pc;
  assign instr_o     = buf_data[0];
  assign pc_o        = buf_pc[0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc          <= reset_pc_p;
      outstanding <= '0;
      discard_cnt <= '0;
      tag_cnt     <= '0;
      count       <= '0;
      state       <= RUN;
    end else begin
      outstanding <= outstanding + OUT_W'(accept) - OUT_W'(imem_resp_v_i);
      if (btaken_i) begin
        pc          <= {br_tgt_i[31:2], 2'b00};
        count       <= '0;
        tag_cnt     <= '0;
        discard_cnt <= stale_left;
        state       <= (stale_left != '0) ? FLUSH : RUN;
      end else begin
        if (accept) pc <= pc + 32'd4;
        count   <= count + CNT_W'(push) - CNT_W'(pop);
        tag_cnt <= tag_cnt + OUT_W'(accept) - OUT_W'(push);
        if (drop) begin
          discard_cnt <= discard_cnt - OUT_W'(1);
          if (discard_cnt == OUT_W'(1)) state <= RUN;
        end
      end
    end
  end

  // Head-at-slot-0 shift queues keep pc_o/instr_o as plain register outputs;
  // the push write is placed after the shift so it wins on the same slot.
  always_ff @(posedge clk_i) begin
    if (pop) begin
      for (int unsigned i = 0; i + 1 < buf_depth_p; i++) begin
        buf_pc[i]   <= buf_pc[i+1];
        buf_data[i] <= buf_data[i+1];
      end
    end
    if (push) begin
      for (int unsigned i = 0; i < buf_depth_p; i++) begin
        if (i == 32'(buf_wr_idx)) begin
          buf_pc[i]   <= tag_q[0];
          buf_data[i] <= imem_resp_data_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      for (int unsigned i = 0; i + 1 < max_outstanding_p; i++) begin
        tag_q[i] <= tag_q[i+1];
      end
    end
    if (accept) begin
      for (int unsigned i = 0; i < max_outstanding_p; i++) begin
        if (i == 32'(tag_wr_idx)) tag_q[i] <= pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a queue-based imem/decode model is
// compared against the DUT every cycle under directed and random stimulus.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int MAXO  = 2;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        stall_v_i = 1'b0;
  logic        btaken_i = 1'b0;
  logic [31:0] br_tgt_i = '0;
  logic        imem_req_v_o;
  logic [31:0] imem_addr_o;
  logic        imem_req_ready_i = 1'b0;
  logic        imem_resp_v_i = 1'b0;
  logic [31:0] imem_resp_data_i = '0;
  logic        instr_v_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;

  always #5 clk = ~clk;

  fetch_stage #(
    .reset_pc_p(RESET_PC),
    .max_outstanding_p(MAXO),
    .buf_depth_p(DEPTH)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .stall_v_i(stall_v_i),
    .btaken_i(btaken_i),
    .br_tgt_i(br_tgt_i),
    .imem_req_v_o(imem_req_v_o),
    .imem_addr_o(imem_addr_o),
    .imem_req_ready_i(imem_req_ready_i),
    .imem_resp_v_i(imem_resp_v_i),
    .imem_resp_data_i(imem_resp_data_i),
    .instr_v_o(instr_v_o),
    .instr_o(instr_o),
    .pc_o(pc_o)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] due;
    logic        stale;
  } req_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  req_t        inflight[$];
  ent_t        fifo[$];
  logic [31:0] acc_log[$];
  logic [31:0] exp_addr = RESET_PC;
  int unsigned cyc = 0;
  int          lat_lo = 1;
  int          lat_hi = 1;
  int          total = 0;
  int          bad = 0;
  logic        pin_armed = 1'b0;
  logic [31:0] pin_pc = '0;
  logic        last_resp = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs after the edge, compare at the falling edge, then
  // advance the model by what the next rising edge will do.
  task automatic step(input logic r, input logic b, input logic [31:0] t,
                      input logic s, input logic rdy);
    req_t cur;
    logic have_resp;
    logic exp_req;
    logic popped;
    int   occ;
    @(posedge clk);
    #1;
    cyc++;
    have_resp = 1'b0;
    cur = '0;
    if (!r && inflight.size() > 0 && inflight[0].due <= cyc) begin
      cur = inflight.pop_front();
      have_resp = 1'b1;
    end
    last_resp = have_resp;
    rst_i = r;
    btaken_i = b;
    br_tgt_i = t;
    stall_v_i = s;
    imem_req_ready_i = rdy;
    imem_resp_v_i = have_resp;
    imem_resp_data_i = have_resp ? mem_word(cur.addr) : $urandom();
    @(negedge clk);
    occ = inflight.size() + int'(have_resp);
    exp_req = !r && !b && (occ < MAXO) && (occ + fifo.size() < DEPTH);
    chk("req_v", {31'b0, imem_req_v_o}, {31'b0, exp_req});
    chk("instr_v", {31'b0, instr_v_o}, {31'b0, (!r && !b && fifo.size() > 0)});
    if (!r) chk("addr", imem_addr_o, exp_addr);
    if (!r && !b && fifo.size() > 0) begin
      chk("pc", pc_o, fifo[0].pc);
      chk("instr", instr_o, fifo[0].data);
    end
    if (r) begin
      inflight.delete();
      fifo.delete();
      exp_addr = RESET_PC;
    end else begin
      popped = (fifo.size() > 0) && !b && !s;
      if (popped) begin
        if (pin_armed) begin
          chk("pin_pc", pc_o, pin_pc);
          pin_armed = 1'b0;
        end
        void'(fifo.pop_front());
      end
      if (have_resp && !b && !cur.stale) fifo.push_back('{pc: cur.addr, data: mem_word(cur.addr)});
      if (exp_req && rdy) begin
        inflight.push_back('{addr: exp_addr, due: cyc + $urandom_range(lat_hi, lat_lo), stale: 1'b0});
        acc_log.push_back(exp_addr);
        exp_addr = exp_addr + 32'd4;
      end
      if (b) begin
        foreach (inflight[i]) inflight[i].stale = 1'b1;
        fifo.delete();
        exp_addr = {t[31:2], 2'b00};
      end
    end
  endtask

  task automatic quiesce();
    for (int k = 0; k < 60 && (inflight.size() > 0 || fifo.size() > 0); k++) step(0, 0, '0, 0, 0);
    chk("quiesce", inflight.size() + fifo.size(), 0);
  endtask

  initial begin
    logic [31:0] hold;
    repeat (3) step(1, 0, '0, 0, 0);
    chk("rst_addr", imem_addr_o, 32'h0000_0000);
    chk("rst_instr_v", {31'b0, instr_v_o}, 0);

    // 1: latency 1, no stall, sequential fetch.
    acc_log.delete();
    for (int k = 0; k < 40; k++) step(0, 0, '0, 0, 1);
    chk("t1_a0", acc_log[0], 32'h0);
    chk("t1_a1", acc_log[1], 32'h4);
    chk("t1_a2", acc_log[2], 32'h8);

    // 2: long stall fills the buffer and blocks issue.
    for (int k = 0; k < 10; k++) step(0, 0, '0, 1, 1);
    chk("t2_full", {31'b0, instr_v_o}, 1);
    chk("t2_noreq", {31'b0, imem_req_v_o}, 0);
    chk("t2_cnt", fifo.size(), DEPTH);
    for (int k = 0; k < 20; k++) step(0, 0, '0, 0, 1);

    // 3: two requests in flight at latency 3, then redirect to 0x100.
    quiesce();
    lat_lo = 3; lat_hi = 3;
    for (int k = 0; k < 20 && inflight.size() < 2; k++) step(0, 0, '0, 0, 1);
    chk("t3_setup", inflight.size(), 2);
    step(0, 1, 32'h0000_0100, 0, 1);
    pin_armed = 1'b1; pin_pc = 32'h0000_0100;
    for (int k = 0; k < 20; k++) step(0, 0, '0, 0, 1);
    chk("t3_pin_seen", {31'b0, pin_armed}, 0);

    // 4: redirect coincides with the only outstanding response.
    quiesce();
    lat_lo = 2; lat_hi = 2;
    step(0, 0, '0, 0, 1);
    step(0, 0, '0, 0, 0);
    step(0, 1, 32'h0000_0200, 0, 0);
    chk("t4_resp_same_cycle", {31'b0, last_resp}, 1);
    lat_lo = 1; lat_hi = 1;
    pin_armed = 1'b1; pin_pc = 32'h0000_0200;
    step(0, 0, '0, 0, 0);
    chk("t4_addr", imem_addr_o, 32'h0000_0200);
    chk("t4_req", {31'b0, imem_req_v_o}, 1);
    for (int k = 0; k < 10; k++) step(0, 0, '0, 0, 1);
    chk("t4_pin_seen", {31'b0, pin_armed}, 0);

    // 5: ready held low keeps the address steady.
    quiesce();
    hold = exp_addr;
    for (int k = 0; k < 5; k++) begin
      step(0, 0, '0, 0, 0);
      chk("t5_hold", imem_addr_o, hold);
    end
    step(0, 0, '0, 0, 1);
    step(0, 0, '0, 1, 0);
    chk("t5_adv", imem_addr_o, hold + 32'd4);

    // 6: reset with a full buffer, then a redirect that wraps the PC.
    for (int k = 0; k < 10; k++) step(0, 0, '0, 1, 1);
    step(1, 0, '0, 1, 1);
    step(0, 0, '0, 0, 0);
    chk("t6_instr_v", {31'b0, instr_v_o}, 0);
    chk("t6_pc", imem_addr_o, RESET_PC);
    step(0, 1, 32'hFFFF_FFFE, 0, 0);
    step(0, 0, '0, 0, 0);
    chk("t6_tgt", imem_addr_o, 32'hFFFF_FFFC);
    step(0, 0, '0, 0, 1);
    step(0, 0, '0, 0, 0);
    chk("t6_wrap", imem_addr_o, 32'h0000_0000);

    // Random traffic: latency, backpressure, stalls, redirects, resets.
    lat_lo = 1; lat_hi = 4;
    for (int k = 0; k < 2000; k++) begin
      logic r, b, s, rdy;
      logic [31:0] t;
      r   = ($urandom_range(199, 0) == 0);
      b   = ($urandom_range(24, 0) == 0);
      s   = ($urandom_range(9, 0) < 3);
      rdy = ($urandom_range(9, 0) < 7);
      t   = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom();
      step(r, b, t, s, rdy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
